// File: rtl/lamp_safety_monitor_if.sv
// Lamp bus between the traffic controller, the safety monitor and the lamp drivers.
// The controller side drives the i_* patterns; the monitor drives the lamp outputs.
interface lamp_safety_monitor_if;
    logic [15:0] i_ct;
    logic [7:0]  i_wt;
    logic [15:0] o_lamp_ct;
    logic [7:0]  o_lamp_wt;
    logic        o_fault;
    logic [2:0]  o_fault_code;

    modport master (
        output i_ct, i_wt,
        input  o_lamp_ct, o_lamp_wt, o_fault, o_fault_code
    );

    modport slave (
        input  i_ct, i_wt,
        output o_lamp_ct, o_lamp_wt, o_fault, o_fault_code
    );
endinterface

// File: rtl/lamp_safety_monitor.sv
// Safety stage between the traffic controller and the lamp drivers: debounces the light
// patterns, forwards only conflict-free ones and latches a flashing-red fault otherwise.
module lamp_safety_monitor #(
    parameter int FILTER     = 2,
    parameter int FLASH_HALF = 5,
    parameter int WDOG       = 0
) (
    input logic                  clk,
    input logic                  reset,
    lamp_safety_monitor_if.slave bus
);
    localparam int WDW = (WDOG > 1) ? $clog2(WDOG) : 1;
    localparam int FW  = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    localparam logic [3:0]     FILT    = 4'(FILTER);
    localparam logic [3:0]     FILT_M1 = 4'(FILTER - 1);
    localparam logic [WDW-1:0] WD_M1   = WDW'((WDOG > 0) ? WDOG - 1 : 0);
    localparam logic [FW-1:0]  FH_M1   = FW'(FLASH_HALF - 1);

    localparam logic [15:0] ALL_RED  = 16'h1111;
    localparam logic [15:0] ALL_DARK = 16'h0000;
    localparam logic [7:0]  NO_WALK  = 8'h55;

    typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_t;

    state_t         state, state_n;
    logic [23:0]    in_q;
    logic [3:0]     cnt, cnt_n;
    logic [15:0]    ct_q, ct_n;
    logic [7:0]     wt_q, wt_n;
    logic           fault_q, fault_n;
    logic [2:0]     code_q, code_n;
    logic [WDW-1:0] wdog_q, wdog_n;
    logic [FW-1:0]  flash_q, flash_n;

    logic [23:0] cand;
    logic        diff, accept, same;
    logic [2:0]  code;

    // Lowest failing rule number wins; 0 means the candidate is legal.
    function automatic logic [2:0] check_code(input logic [15:0] ct, input logic [7:0] wt,
                                              input logic [15:0] cur_ct, input logic in_run);
        logic       bad_lamp, bad_walk, walk_conf, green_red, ns_go, ew_go;
        logic [3:0] n;
        logic [1:0] w;
        logic [2:0] c;
        bad_lamp  = 1'b0;
        bad_walk  = 1'b0;
        walk_conf = 1'b0;
        green_red = 1'b0;
        ns_go     = 1'b0;
        ew_go     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n = ct[4*k +: 4];
            w = wt[2*k +: 2];
            if (!(n[2:0] == 3'b001 || n[2:0] == 3'b010 || n[2:0] == 3'b100) || (n[3] && !n[2]))
                bad_lamp = 1'b1;
            if (!(w == 2'b01 || w == 2'b10))
                bad_walk = 1'b1;
            if (w[1] && !n[0])
                walk_conf = 1'b1;
            if (in_run && cur_ct[4*k+2] && n[0])
                green_red = 1'b1;
            if (!n[0]) begin
                if (k % 2 == 1) ew_go = 1'b1;
                else            ns_go = 1'b1;
            end
        end
        if (bad_lamp)            c = 3'd1;
        else if (ns_go && ew_go) c = 3'd2;
        else if (walk_conf)      c = 3'd3;
        else if (green_red)      c = 3'd4;
        else if (bad_walk)       c = 3'd5;
        else                     c = 3'd0;
        return c;
    endfunction

    always_comb begin
        cand   = {bus.i_ct, bus.i_wt};
        diff   = (cand != in_q);
        cnt_n  = diff ? 4'd1 : ((cnt == FILT) ? cnt : cnt + 4'd1);
        // Fires once per stable pattern: on the FILTER-th consecutive identical sample.
        accept = diff ? (FILTER == 1) : (cnt == FILT_M1);
        same   = (cand == {ct_q, wt_q});
        code   = check_code(cand[23:8], cand[7:0], ct_q, state == S_RUN);
    end

    always_comb begin
        state_n = state;
        ct_n    = ct_q;
        wt_n    = wt_q;
        fault_n = fault_q;
        code_n  = code_q;
        wdog_n  = wdog_q;
        flash_n = flash_q;
        case (state)
            S_INIT: begin
                // An all-zero bus means the controller is not yet driving; wait for it.
                if (accept && cand != '0) begin
                    if (same) begin
                        state_n = S_RUN;
                    end else if (code == 3'd0) begin
                        state_n = S_RUN;
                        ct_n    = cand[23:8];
                        wt_n    = cand[7:0];
                        wdog_n  = '0;
                    end else begin
                        state_n = S_FAULT;
                        fault_n = 1'b1;
                        code_n  = code;
                        ct_n    = ALL_RED;
                        wt_n    = NO_WALK;
                        flash_n = '0;
                    end
                end
            end
            S_RUN: begin
                if (accept && !same) begin
                    if (code == 3'd0) begin
                        ct_n   = cand[23:8];
                        wt_n   = cand[7:0];
                        wdog_n = '0;
                    end else begin
                        state_n = S_FAULT;
                        fault_n = 1'b1;
                        code_n  = code;
                        ct_n    = ALL_RED;
                        wt_n    = NO_WALK;
                        flash_n = '0;
                    end
                end else if (WDOG != 0) begin
                    if (wdog_q == WD_M1) begin
                        state_n = S_FAULT;
                        fault_n = 1'b1;
                        code_n  = 3'd6;
                        ct_n    = ALL_RED;
                        wt_n    = NO_WALK;
                        flash_n = '0;
                    end else begin
                        wdog_n = wdog_q + 1'b1;
                    end
                end
            end
            S_FAULT: begin
                wt_n = NO_WALK;
                if (flash_q == FH_M1) begin
                    flash_n = '0;
                    ct_n    = (ct_q == ALL_RED) ? ALL_DARK : ALL_RED;
                end else begin
                    flash_n = flash_q + 1'b1;
                end
            end
            default: state_n = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_INIT;
            in_q    <= '0;
            cnt     <= '0;
            ct_q    <= ALL_RED;
            wt_q    <= NO_WALK;
            fault_q <= 1'b0;
            code_q  <= 3'd0;
            wdog_q  <= '0;
            flash_q <= '0;
        end else begin
            state   <= state_n;
            in_q    <= cand;
            cnt     <= cnt_n;
            ct_q    <= ct_n;
            wt_q    <= wt_n;
            fault_q <= fault_n;
            code_q  <= code_n;
            wdog_q  <= wdog_n;
            flash_q <= flash_n;
        end
    end

    assign bus.o_lamp_ct    = ct_q;
    assign bus.o_lamp_wt    = wt_q;
    assign bus.o_fault      = fault_q;
    assign bus.o_fault_code = code_q;
endmodule

// File: tb/tb_lamp_safety_monitor.sv
// Directed bench for lamp_safety_monitor: vector table plus flash, watchdog and async-reset sequences.
module tb_lamp_safety_monitor;
    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;

    always #5 clk = ~clk;

    lamp_safety_monitor_if b1();
    lamp_safety_monitor_if b2();

    lamp_safety_monitor #(.FILTER(2), .FLASH_HALF(5), .WDOG(0)) dut1 (
        .clk(clk), .reset(rst1), .bus(b1)
    );
    lamp_safety_monitor #(.FILTER(2), .FLASH_HALF(5), .WDOG(20)) dut2 (
        .clk(clk), .reset(rst2), .bus(b2)
    );

    typedef struct {
        logic        rst;
        logic [15:0] ct;
        logic [7:0]  wt;
        int          hold;
        logic [15:0] exp_ct;
        logic [7:0]  exp_wt;
        logic        exp_fault;
        logic [2:0]  exp_code;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [27:0] pack(input logic [15:0] ct, input logic [7:0] wt,
                                         input logic f, input logic [2:0] c);
        return {ct, wt, f, c};
    endfunction

    task automatic chk(input string nm, input logic [27:0] act, input logic [27:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got ct=%h wt=%h fault=%b code=%0d, expected ct=%h wt=%h fault=%b code=%0d",
                     nm, act[27:12], act[11:4], act[3], act[2:0], exp[27:12], exp[11:4], exp[3], exp[2:0]);
        end
    endtask

    function automatic logic [27:0] out1();
        return pack(b1.o_lamp_ct, b1.o_lamp_wt, b1.o_fault, b1.o_fault_code);
    endfunction

    function automatic logic [27:0] out2();
        return pack(b2.o_lamp_ct, b2.o_lamp_wt, b2.o_fault, b2.o_fault_code);
    endfunction

    task automatic add(input logic r, input logic [15:0] ct, input logic [7:0] wt, input int hold,
                       input logic [15:0] ect, input logic [7:0] ewt, input logic ef,
                       input logic [2:0] ec, input string nm);
        vec_t v;
        v.rst = r; v.ct = ct; v.wt = wt; v.hold = hold;
        v.exp_ct = ect; v.exp_wt = ewt; v.exp_fault = ef; v.exp_code = ec; v.name = nm;
        vecs.push_back(v);
    endtask

    initial begin
        b1.i_ct = '0; b1.i_wt = '0;
        b2.i_ct = '0; b2.i_wt = '0;

        //   rst  ct        wt     hold exp_ct    exp_wt f  code
        add(1'b1, 16'h0000, 8'h00, 0, 16'h1111, 8'h55, 0, 0, "reset");
        add(1'b0, 16'h0000, 8'h00, 6, 16'h1111, 8'h55, 0, 0, "idle_zero");
        add(1'b0, 16'h1414, 8'h99, 1, 16'h1111, 8'h55, 0, 0, "latency_e0");
        add(1'b0, 16'h1414, 8'h99, 1, 16'h1414, 8'h99, 0, 0, "latency_e1");
        add(1'b0, 16'h4444, 8'h99, 1, 16'h1414, 8'h99, 0, 0, "glitch");
        add(1'b0, 16'h1414, 8'h99, 3, 16'h1414, 8'h99, 0, 0, "glitch_gone");
        add(1'b0, 16'h1212, 8'h99, 1, 16'h1414, 8'h99, 0, 0, "restart_a");
        add(1'b0, 16'h1111, 8'h55, 1, 16'h1414, 8'h99, 0, 0, "restart_b");
        add(1'b0, 16'h1212, 8'h99, 3, 16'h1212, 8'h99, 0, 0, "yellow");
        add(1'b0, 16'h1111, 8'h55, 4, 16'h1111, 8'h55, 0, 0, "all_red");
        add(1'b0, 16'h1414, 8'h99, 4, 16'h1414, 8'h99, 0, 0, "green_again");
        add(1'b0, 16'h1111, 8'h55, 4, 16'h1111, 8'h55, 1, 4, "code4_green_red");
        add(1'b1, 16'h4444, 8'h55, 2, 16'h1111, 8'h55, 1, 2, "code2_axis");
        add(1'b1, 16'h1614, 8'h99, 2, 16'h1111, 8'h55, 1, 1, "code1_onehot");
        add(1'b1, 16'h1419, 8'h99, 2, 16'h1111, 8'h55, 1, 1, "code1_arrow");
        add(1'b1, 16'h1414, 8'h98, 2, 16'h1111, 8'h55, 1, 5, "code5_walk");
        add(1'b1, 16'h1414, 8'h96, 2, 16'h1111, 8'h55, 1, 3, "code3_walk_conf");
        add(1'b1, 16'h4444, 8'hFF, 2, 16'h1111, 8'h55, 1, 2, "prio_2_over_5");
        add(1'b1, 16'h1C1C, 8'h99, 2, 16'h1C1C, 8'h99, 0, 0, "arrow_ok");
        add(1'b1, 16'h1C1C, 8'h99, 1, 16'h1111, 8'h55, 0, 0, "init_latency");
        add(1'b0, 16'h1C1C, 8'h99, 1, 16'h1C1C, 8'h99, 0, 0, "arrow_ok2");
        add(1'b0, 16'h1111, 8'h55, 2, 16'h1111, 8'h55, 1, 4, "code4_arrow");

        @(negedge clk);
        rst2 = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            b1.i_ct = vecs[i].ct;
            b1.i_wt = vecs[i].wt;
            if (vecs[i].rst) begin
                rst1 = 1'b1;
                @(negedge clk);
                rst1 = 1'b0;
            end
            repeat (vecs[i].hold) @(negedge clk);
            chk(vecs[i].name, out1(),
                pack(vecs[i].exp_ct, vecs[i].exp_wt, vecs[i].exp_fault, vecs[i].exp_code));
        end

        // Flash cadence after an axis conflict, inputs ignored, then async reset mid-flash.
        b1.i_ct = 16'h4444; b1.i_wt = 8'h55;
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("flash_entry", out1(), pack(16'h1111, 8'h55, 1'b1, 3'd2));
        b1.i_ct = 16'h1414; b1.i_wt = 8'h99;
        repeat (4) @(negedge clk);
        chk("flash_red_end", out1(), pack(16'h1111, 8'h55, 1'b1, 3'd2));
        @(negedge clk);
        chk("flash_dark", out1(), pack(16'h0000, 8'h55, 1'b1, 3'd2));
        repeat (4) @(negedge clk);
        chk("flash_dark_end", out1(), pack(16'h0000, 8'h55, 1'b1, 3'd2));
        @(negedge clk);
        chk("flash_red_again", out1(), pack(16'h1111, 8'h55, 1'b1, 3'd2));
        repeat (6) @(negedge clk);
        chk("flash_dark_again", out1(), pack(16'h0000, 8'h55, 1'b1, 3'd2));
        #2 rst1 = 1'b1;
        #1 chk("async_reset", out1(), pack(16'h1111, 8'h55, 1'b0, 3'd0));
        @(negedge clk);
        rst1 = 1'b0;

        // Watchdog: pattern held constant in RUN trips code 6 twenty edges after acceptance.
        b2.i_ct = 16'h1414; b2.i_wt = 8'h99;
        repeat (2) @(negedge clk);
        chk("wdog_accept", out2(), pack(16'h1414, 8'h99, 1'b0, 3'd0));
        repeat (19) @(negedge clk);
        chk("wdog_edge19", out2(), pack(16'h1414, 8'h99, 1'b0, 3'd0));
        @(negedge clk);
        chk("wdog_edge20", out2(), pack(16'h1111, 8'h55, 1'b1, 3'd6));
        repeat (3) @(negedge clk);
        #2 rst2 = 1'b1;
        #1 chk("wdog_async_reset", out2(), pack(16'h1111, 8'h55, 1'b0, 3'd0));
        @(negedge clk);
        rst2 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
